// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: walks quadA/quadB toward a signed target, one count per step_div cycles.
// Optional index output and revolution counter are built only when QUAD_INDEX_EN is defined.
module quad_encoder_gen #(
    parameter int POS_W = 32,
    parameter int DIV_W = 16,
    parameter int CPR   = 2048
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [POS_W-1:0] target,
    input  logic [DIV_W-1:0]        step_div,
    output logic                    quadA,
    output logic                    quadB,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
    output logic                    at_target
`ifdef QUAD_INDEX_EN
    ,
    output logic                    index
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MOVE = 1'b1
    } state_t;

    // Channel A for a given phase: ph[1]^ph[0] gives the A-leads-B Gray sequence
    function automatic logic enc_a(input logic [1:0] ph);
        return ph[1] ^ ph[0];
    endfunction

    function automatic logic enc_b(input logic [1:0] ph);
        return ph[1];
    endfunction

    if (CPR < 2) begin : g_bad_cpr
        $error("quad_encoder_gen: CPR must be at least 2");
    end

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DIV_W-1:0]          r_cnt;
    logic [DIV_W-1:0]          w_cnt_nxt;
    logic [DIV_W-1:0]          w_reload;
    logic signed [POS_W-1:0]   r_position;
    logic signed [POS_W-1:0]   w_pos_nxt;
    logic                      r_quad_a;
    logic                      r_quad_b;
    logic                      r_busy;
    logic                      r_at_target;

    // Countdown reload value; a step_div of zero behaves as one
    assign w_reload = (step_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (step_div - DIV_W'(1));

    // Next-state, countdown and position update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_position;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_cnt_nxt = {DIV_W{1'b0}};
                    if (target != r_position) begin
                        w_state_nxt = S_MOVE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_MOVE: begin
                if (!enable) begin
                    w_state_nxt = r_state;
                end else if (r_cnt != {DIV_W{1'b0}}) begin
                    w_cnt_nxt = r_cnt - DIV_W'(1);
                end else if (target > r_position) begin
                    w_pos_nxt = r_position + POS_W'(1);
                    w_cnt_nxt = w_reload;
                end else if (target < r_position) begin
                    w_pos_nxt = r_position - POS_W'(1);
                    w_cnt_nxt = w_reload;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {DIV_W{1'b0}};
            end
        endcase
    end

    // State, position and registered outputs; channels are encoded from the next position
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= {DIV_W{1'b0}};
            r_position  <= {POS_W{1'b0}};
            r_quad_a    <= 1'b0;
            r_quad_b    <= 1'b0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_position  <= w_pos_nxt;
            r_quad_a    <= enc_a(w_pos_nxt[1:0]);
            r_quad_b    <= enc_b(w_pos_nxt[1:0]);
            r_busy      <= (w_state_nxt == S_MOVE);
            r_at_target <= (r_position == target);
        end
    end

    assign quadA     = r_quad_a;
    assign quadB     = r_quad_b;
    assign position  = r_position;
    assign busy      = r_busy;
    assign at_target = r_at_target;

`ifdef QUAD_INDEX_EN
    localparam int REV_W = $clog2(CPR);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

    logic [REV_W-1:0] r_rev_cnt;
    logic [REV_W-1:0] w_rev_nxt;
    logic             r_index;

    // Revolution counter follows the step direction and wraps within [0, CPR-1]
    always_comb begin
        w_rev_nxt = r_rev_cnt;
        if (w_pos_nxt > r_position) begin
            w_rev_nxt = (r_rev_cnt == REV_MAX) ? {REV_W{1'b0}} : (r_rev_cnt + REV_W'(1));
        end else if (w_pos_nxt < r_position) begin
            w_rev_nxt = (r_rev_cnt == {REV_W{1'b0}}) ? REV_MAX : (r_rev_cnt - REV_W'(1));
        end else begin
            w_rev_nxt = r_rev_cnt;
        end
    end

    // Index is high for the whole count at revolution zero, aligned with the channel edge
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_rev_cnt <= {REV_W{1'b0}};
            r_index   <= 1'b1;
        end else begin
            r_rev_cnt <= w_rev_nxt;
            r_index   <= (w_rev_nxt == {REV_W{1'b0}});
        end
    end

    assign index = r_index;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: scoreboard of expected (A,B,position,spacing) per emitted edge.
module tb_quad_encoder_gen;

`ifdef QUAD_INDEX_EN
    localparam int BENCH_CPR = 4;
`else
    localparam int BENCH_CPR = 2048;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b1;
    logic signed [31:0] target = 32'sd0;
    logic [15:0]        step_div = 16'd1;
    logic               quadA;
    logic               quadB;
    logic signed [31:0] position;
    logic               busy;
    logic               at_target;
`ifdef QUAD_INDEX_EN
    logic               index;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]         ab;
        logic signed [31:0] pos;
        int                 gap;
    } exp_t;

    exp_t               sb[$];
    int                 cyc = 0;
    int                 last_edge = 0;
    logic signed [31:0] prev_pos = 'x;
    logic [1:0]         prev_ab = 2'b00;
    int                 dec_cnt = 0;

    quad_encoder_gen #(.POS_W(32), .DIV_W(16), .CPR(BENCH_CPR)) dut (
        .CLK       (clk),
        .reset     (rst_n),
        .enable    (enable),
        .target    (target),
        .step_div  (step_div),
        .quadA     (quadA),
        .quadB     (quadB),
        .position  (position),
        .busy      (busy),
        .at_target (at_target)
`ifdef QUAD_INDEX_EN
        ,
        .index     (index)
`endif
    );

    always #5 clk = ~clk;

    // (A,B) for a position: 00 -> 10 -> 11 -> 01 on increasing counts
    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void push_exp(input int p, input int g);
        exp_t e;
        e.ab  = ab_of(p);
        e.pos = p;
        e.gap = g;
        sb.push_back(e);
    endfunction

    // Monitor: independent quadrature decoder plus scoreboard pop on every position change
    always @(negedge clk) begin
        int d;
        exp_t e;
        cyc = cyc + 1;
        if (!rst_n) begin
            dec_cnt = 0;
            prev_ab = {quadA, quadB};
        end else if ({quadA, quadB} !== prev_ab) begin
            d = (gray_idx({quadA, quadB}) - gray_idx(prev_ab)) & 3;
            if (d == 1) dec_cnt = dec_cnt + 1;
            else if (d == 3) dec_cnt = dec_cnt - 1;
            else begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL decode: AB %b -> %b is not a single-channel step", prev_ab, {quadA, quadB});
            end
            prev_ab = {quadA, quadB};
        end
        if (!$isunknown(prev_pos) && position !== prev_pos) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_edge: position %0d -> %0d with nothing expected", prev_pos, position);
            end else begin
                e = sb.pop_front();
                if ({quadA, quadB} !== e.ab || position !== e.pos) begin
                    errors = errors + 1;
                    $display("FAIL edge: got AB=%b pos=%0d, expected AB=%b pos=%0d",
                             {quadA, quadB}, position, e.ab, e.pos);
                end else if (e.gap > 0 && (cyc - last_edge) != e.gap) begin
                    errors = errors + 1;
                    $display("FAIL spacing: pos=%0d got %0d cycles, expected %0d", position, cyc - last_edge, e.gap);
                end
            end
            last_edge = cyc;
        end
        prev_pos = position;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        ok = (sb.size() == 0);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        ok = (busy === 1'b0);
    endtask

    task automatic apply_reset();
        tick();
        if (position !== 32'sd0 && !$isunknown(position)) push_exp(0, 0);
        rst_n  = 1'b0;
        enable = 1'b1;
        target = 32'sd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks = checks + 1;
        if ({quadA, quadB, busy, at_target} !== 4'b0000 || position !== 32'sd0) begin
            errors = errors + 1;
            $display("FAIL reset: got A=%b B=%b busy=%b at=%b pos=%0d, expected all 0",
                     quadA, quadB, busy, at_target, position);
        end
`ifdef QUAD_INDEX_EN
        checks = checks + 1;
        if (index !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset_index: got %b expected 1", index);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        bit ok;
        apply_reset();
        step_div = 16'd4;
        push_exp(1, 0);
        for (int p = 2; p <= 5; p++) push_exp(p, 4);
        target = 32'sd5;
        wait_drain(100, ok);
        checks = checks + 1;
        if (!ok) begin errors = errors + 1; $display("FAIL fwd_timeout: %0d edges missing, expected 0", sb.size()); end
        wait_idle(50, ok);
        tick();
        checks = checks + 1;
        if (!ok || at_target !== 1'b1 || position !== 32'sd5 || dec_cnt != 5) begin
            errors = errors + 1;
            $display("FAIL fwd_end: busy=%b at=%b pos=%0d dec=%0d, expected 0 1 5 5", busy, at_target, position, dec_cnt);
        end
    endtask

    task automatic test_reverse();
        bit ok;
        apply_reset();
        step_div = 16'd2;
        push_exp(-1, 0);
        push_exp(-2, 2);
        push_exp(-3, 2);
        target = -32'sd3;
        wait_drain(100, ok);
        wait_idle(50, ok);
        tick();
        checks = checks + 1;
        if (!ok || position !== -32'sd3 || dec_cnt != -3 || at_target !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL rev_end: busy=%b pos=%0d dec=%0d at=%b, expected 0 -3 -3 1", busy, position, dec_cnt, at_target);
        end
    endtask

    task automatic test_div_zero();
        int n = 0;
        apply_reset();
        step_div = 16'd0;
        push_exp(1, 0);
        for (int p = 2; p <= 8; p++) push_exp(p, 1);
        target = 32'sd8;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (position === 32'sd8) break;
        end
        checks = checks + 1;
        if (n != 9 || position !== 32'sd8) begin
            errors = errors + 1;
            $display("FAIL div0_latency: reached pos=%0d after %0d cycles, expected 8 after 9", position, n);
        end
    endtask

    task automatic test_retarget();
        bit ok;
        apply_reset();
        step_div = 16'd3;
        push_exp(1, 0);
        for (int p = 2; p <= 4; p++) push_exp(p, 3);
        target = 32'sd10;
        wait_drain(100, ok);
        push_exp(3, 3);
        push_exp(2, 3);
        target = 32'sd2;
        wait_drain(100, ok);
        wait_idle(50, ok);
        repeat (10) tick();
        checks = checks + 1;
        if (!ok || position !== 32'sd2 || dec_cnt != 2 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL retarget_end: busy=%b pos=%0d dec=%0d, expected 0 2 2", busy, position, dec_cnt);
        end
    endtask

    task automatic test_freeze();
        bit ok;
        apply_reset();
        step_div = 16'd5;
        push_exp(1, 0);
        push_exp(2, 5);
        target = 32'sd6;
        wait_drain(100, ok);
        push_exp(3, 25);
        for (int p = 4; p <= 6; p++) push_exp(p, 5);
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks = checks + 1;
            if (position !== 32'sd2 || {quadA, quadB} !== 2'b11 || busy !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL freeze[%0d]: pos=%0d AB=%b busy=%b, expected 2 11 1", i, position, {quadA, quadB}, busy);
            end
            if (i == 4) target = 32'sd2;
            if (i == 5) begin
                checks = checks + 1;
                if (at_target !== 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL freeze_at_target: got %b expected 1", at_target);
                end
                target = 32'sd6;
            end
        end
        enable = 1'b1;
        wait_drain(200, ok);
        wait_idle(50, ok);
        checks = checks + 1;
        if (!ok || position !== 32'sd6) begin
            errors = errors + 1;
            $display("FAIL freeze_end: busy=%b pos=%0d, expected 0 6", busy, position);
        end
    endtask

    task automatic test_reset_midmove();
        bit ok;
        apply_reset();
        step_div = 16'd2;
        push_exp(1, 0);
        push_exp(2, 2);
        push_exp(3, 2);
        target = 32'sd6;
        wait_drain(100, ok);
        checks = checks + 1;
        if (!ok || busy !== 1'b1 || position !== 32'sd3) begin
            errors = errors + 1;
            $display("FAIL midmove_pre: busy=%b pos=%0d, expected 1 3", busy, position);
        end
        push_exp(0, 0);
        rst_n = 1'b0;
        tick();
        checks = checks + 1;
        if (position !== 32'sd0 || {quadA, quadB, busy, at_target} !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL midmove_reset: pos=%0d A=%b B=%b busy=%b at=%b, expected all 0",
                     position, quadA, quadB, busy, at_target);
        end
        target = 32'sd0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_large_target();
        bit ok;
        apply_reset();
        step_div = 16'd1;
        push_exp(1, 0);
        for (int p = 2; p <= 10; p++) push_exp(p, 1);
        target = 32'sh7FFF_FFFF;
        wait_drain(100, ok);
        enable = 1'b0;
        repeat (3) tick();
        checks = checks + 1;
        if (!ok || position !== 32'sd10 || busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL large_target: pos=%0d busy=%b, expected 10 1", position, busy);
        end
    endtask

`ifdef QUAD_INDEX_EN
    task automatic test_index();
        bit ok;
        apply_reset();
        checks = checks + 1;
        if (index !== 1'b1) begin errors = errors + 1; $display("FAIL index_rst: got %b expected 1", index); end
        step_div = 16'd1;
        push_exp(-1, 0);
        target = -32'sd1;
        wait_drain(50, ok);
        checks = checks + 1;
        if (!ok || index !== 1'b0 || dut.r_rev_cnt !== 2'd3) begin
            errors = errors + 1;
            $display("FAIL index_down: index=%b rev=%0d, expected 0 3", index, dut.r_rev_cnt);
        end
        wait_idle(20, ok);
        push_exp(0, 0);
        target = 32'sd0;
        wait_drain(50, ok);
        checks = checks + 1;
        if (!ok || index !== 1'b1 || dut.r_rev_cnt !== 2'd0) begin
            errors = errors + 1;
            $display("FAIL index_up: index=%b rev=%0d, expected 1 0", index, dut.r_rev_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_div_zero();
        test_retarget();
        test_freeze();
        test_reset_midmove();
        test_large_target();
        apply_reset();
`ifdef QUAD_INDEX_EN
        test_index();
`endif
        repeat (3) tick();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
